// File: rtl/conv_pkg.sv
// Shared types and window slicing constants for the 3x3 convolution line buffer.
package conv_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int WIN_TAPS  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } lb_state_e;

   // Tap index k occupies win_data[k*PIX_W +: PIX_W]; top-left is the most significant tap.
   localparam int WIN_TL = 8;
   localparam int WIN_TC = 7;
   localparam int WIN_TR = 6;
   localparam int WIN_ML = 5;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 3;
   localparam int WIN_BL = 2;
   localparam int WIN_BC = 1;
   localparam int WIN_BR = 0;

   localparam logic [9:0] ROW_MAX = 10'd1023;

endpackage

// File: rtl/conv_row_ram.sv
// One line of pixel storage: asynchronous read and synchronous write on the same
// address, so a same-cycle read returns the value from before the write.
module conv_row_ram #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 8,
   parameter int AW     = 6
)(
   input  logic              HCLK,
   input  logic              wr_en,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   // Contents are deliberately not reset; the fill phase keeps stale data out of windows.
   always_ff @(posedge HCLK) begin
      if (wr_en) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/conv_line_buffer.sv
// Streaming 3x3 window generator built from two row stores and a window shift register.
// Define CONV_LB_FRAME_CNT_EN to add the frame_cnt / win_cnt debug counters.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int MAX_WIDTH = 64,
   parameter int PIX_W     = PIX_W_DEF
)(
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [9:0]                cfg_width,
   input  logic                      pix_valid,
   input  logic                      pix_sof,
   input  logic [PIX_W-1:0]          pix_data,
   output logic                      pix_ready,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [WIN_TAPS*PIX_W-1:0] win_data
`ifdef CONV_LB_FRAME_CNT_EN
   ,
   output logic [15:0]               frame_cnt,
   output logic [15:0]               win_cnt
`endif
);

   localparam int         AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [9:0] MAX_W = 10'(MAX_WIDTH);

   lb_state_e state, state_next;

   logic [9:0] col, row, eff_width;
   logic [9:0] cur_col, cur_row, cur_width, sof_width;
   logic [9:0] col_next, row_next;
   logic       accept, process, wrap, at_window;
   logic [PIX_W-1:0]          row1_rd, row2_rd;
   logic [WIN_TAPS*PIX_W-1:0] win_next;

   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign process   = accept && (pix_sof || state != IDLE);
   assign sof_width = (cfg_width < MAX_W) ? cfg_width : MAX_W;

   // An SOF pixel restarts the raster at (0,0) with the freshly sampled width.
   always_comb begin
      cur_col   = pix_sof ? '0 : col;
      cur_row   = pix_sof ? '0 : row;
      cur_width = pix_sof ? sof_width : eff_width;
      wrap      = ({1'b0, cur_col} + 11'd1) >= {1'b0, cur_width};
      at_window = (cur_row >= 10'd2) && (cur_col >= 10'd2);
      col_next  = wrap ? '0 : cur_col + 10'd1;
      row_next  = cur_row;
      if (wrap && cur_row != ROW_MAX) row_next = cur_row + 10'd1;

      win_next = '0;
      win_next[WIN_TL*PIX_W +: PIX_W] = win_data[WIN_TC*PIX_W +: PIX_W];
      win_next[WIN_TC*PIX_W +: PIX_W] = win_data[WIN_TR*PIX_W +: PIX_W];
      win_next[WIN_TR*PIX_W +: PIX_W] = row2_rd;
      win_next[WIN_ML*PIX_W +: PIX_W] = win_data[WIN_MC*PIX_W +: PIX_W];
      win_next[WIN_MC*PIX_W +: PIX_W] = win_data[WIN_MR*PIX_W +: PIX_W];
      win_next[WIN_MR*PIX_W +: PIX_W] = row1_rd;
      win_next[WIN_BL*PIX_W +: PIX_W] = win_data[WIN_BC*PIX_W +: PIX_W];
      win_next[WIN_BC*PIX_W +: PIX_W] = win_data[WIN_BR*PIX_W +: PIX_W];
      win_next[WIN_BR*PIX_W +: PIX_W] = pix_data;
   end

   conv_row_ram #(.DEPTH(MAX_WIDTH), .DATA_W(PIX_W), .AW(AW)) u_row1 (
      .HCLK    (HCLK),
      .wr_en   (process),
      .addr    (cur_col[AW-1:0]),
      .wr_data (pix_data),
      .rd_data (row1_rd)
   );

   conv_row_ram #(.DEPTH(MAX_WIDTH), .DATA_W(PIX_W), .AW(AW)) u_row2 (
      .HCLK    (HCLK),
      .wr_en   (process),
      .addr    (cur_col[AW-1:0]),
      .wr_data (row1_rd),
      .rd_data (row2_rd)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (process) begin
         if (wrap)           state_next = FILL;
         else if (at_window) state_next = RUN;
         else                state_next = FILL;
      end
   end

   // Dropped IDLE pixels still consume the pending window because they imply pix_ready.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         col       <= '0;
         row       <= '0;
         eff_width <= MAX_W;
         win_valid <= 1'b0;
         win_data  <= '0;
      end else if (process) begin
         col       <= col_next;
         row       <= row_next;
         win_data  <= win_next;
         win_valid <= at_window;
         if (pix_sof) eff_width <= sof_width;
      end else if (accept || win_ready) begin
         win_valid <= 1'b0;
      end
   end

`ifdef CONV_LB_FRAME_CNT_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         frame_cnt <= '0;
         win_cnt   <= '0;
      end else begin
         if (accept && pix_sof) frame_cnt <= frame_cnt + 16'd1;
         if (accept && pix_sof)            win_cnt <= '0;
         else if (win_valid && win_ready)  win_cnt <= win_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer: an image-array model queues expected windows,
// a monitor pops them on each handshake. Counter checks need CONV_LB_FRAME_CNT_EN.
module tb_conv_line_buffer;

   localparam int MAXW = 64;
   localparam int PW   = 8;
   localparam int WW   = 9 * PW;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [9:0]    cfg_width = 10'd4;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [PW-1:0] pix_data = '0;
   logic          pix_ready;
   logic          win_valid;
   logic          win_ready = 1'b1;
   logic [WW-1:0] win_data;
`ifdef CONV_LB_FRAME_CNT_EN
   logic [15:0]   frame_cnt, win_cnt;
`endif

   always #5 HCLK = ~HCLK;

   conv_line_buffer #(.MAX_WIDTH(MAXW), .PIX_W(PW)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cfg_width (cfg_width),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .pix_data  (pix_data),
      .pix_ready (pix_ready),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_data  (win_data)
`ifdef CONV_LB_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt),
      .win_cnt   (win_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] seen_q[$];

   // Reference model: the current frame as an image with three live rows.
   logic [PW-1:0] img [3][MAXW];
   int  m_col, m_row, m_width;
   bit  m_active = 1'b0;

   int  stall_left = 0;
   bit  rand_ready = 1'b0;

   task automatic check(input string name, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic model_pixel(input bit sof, input logic [PW-1:0] d);
      logic [WW-1:0] w;
      if (sof) begin
         m_active = 1'b1;
         m_col    = 0;
         m_row    = 0;
         m_width  = (int'(cfg_width) < MAXW) ? int'(cfg_width) : MAXW;
      end
      if (!m_active) return;
      img[m_row % 3][m_col] = d;
      if (m_row >= 2 && m_col >= 2) begin
         w = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w = {w[WW-PW-1:0], img[(m_row - 2 + r) % 3][m_col - 2 + c]};
         exp_q.push_back(w);
      end
      m_col++;
      if (m_col >= m_width) begin
         m_col = 0;
         if (m_row < 1023) m_row++;
      end
   endtask

   // Presents one pixel from the falling edge and holds it until it is accepted.
   task automatic applyStimulus(input bit sof, input logic [PW-1:0] d, output int waits);
      waits = 0;
      @(negedge HCLK);
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_data  = d;
      forever begin
         #1;
         if (pix_ready) break;
         waits++;
         if (waits > 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL pix_accept_timeout: got pix_ready=0 for %0d cycles expected acceptance", waits);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            return;
         end
         @(negedge HCLK);
      end
      model_pixel(sof, d);
      @(posedge HCLK);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge HCLK);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d windows outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge HCLK);
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      #3;
      HRESETn   = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      exp_q.delete();
      m_active  = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      #2;
      check("reset_win_valid", WW'(win_valid), WW'(0));
      check("reset_pix_ready", WW'(pix_ready), WW'(1));
      check("reset_win_data",  win_data,       WW'(0));
   endtask

   task automatic frame16(input bit stall);
      int base, w, total_waits;
      base        = seen_q.size();
      total_waits = 0;
      cfg_width   = 10'd4;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(i == 1, PW'(i), w);
         if (stall && i == 11) stall_left = 3;
         if (stall && i == 12) check("stall_pix_ready_cycles", WW'(w), WW'(3));
         else total_waits += w;
      end
      check("frame_full_rate", WW'(total_waits), WW'(0));
      drain();
      check("frame_win_count", WW'(seen_q.size() - base), WW'(4));
      if (seen_q.size() >= base + 4) begin
         check("frame_first_win", seen_q[base],     72'h01_02_03_05_06_07_09_0a_0b);
         check("frame_last_win",  seen_q[base + 3], 72'h06_07_08_0a_0b_0c_0e_0f_10);
      end
   endtask

   always @(negedge HCLK) begin
      if (stall_left > 0) begin
         win_ready = 1'b0;
         stall_left--;
      end else if (rand_ready) win_ready = ($urandom_range(0, 3) != 0);
      else                     win_ready = 1'b1;
   end

   // Monitor: compares every handed-off window and checks that stalled windows hold.
   bit            held = 1'b0;
   logic [WW-1:0] held_data;
   always begin
      @(negedge HCLK);
      #2;
      if (!HRESETn) held = 1'b0;
      else if (win_valid) begin
         if (held) check("win_hold", win_data, held_data);
         if (win_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_window: got %0h expected none", win_data);
            end else checkOutput(exp_q.pop_front());
            seen_q.push_back(win_data);
            held = 1'b0;
         end else begin
            held      = 1'b1;
            held_data = win_data;
         end
      end else begin
         if (held) begin
            checks++;
            errors++;
            $display("[TB] FAIL win_dropped: got win_valid=0 expected 1 while stalled");
         end
         held = 1'b0;
      end
   end

   task automatic checkOutput(input logic [WW-1:0] expected);
      check("win_data", win_data, expected);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w, base, total_waits, npix, rows;

      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      #2;
      check("reset_win_valid", WW'(win_valid), WW'(0));
      check("reset_pix_ready", WW'(pix_ready), WW'(1));
      check("reset_win_data",  win_data,       WW'(0));

      frame16(1'b0);
      frame16(1'b1);

      // Too-narrow line: everything accepted, no window ever formed.
      cfg_width   = 10'd2;
      base        = seen_q.size();
      total_waits = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i == 0, PW'($urandom), w);
         total_waits += w;
      end
      drain();
      check("narrow_accept_all", WW'(total_waits), WW'(0));
      check("narrow_no_window",  WW'(seen_q.size() - base), WW'(0));

      // Oversized width clamps to MAX_WIDTH: first window on pixel 2*64+3.
      cfg_width = 10'd200;
      base      = seen_q.size();
      for (int i = 0; i < 2 * MAXW + 2; i++) applyStimulus(i == 0, PW'($urandom), w);
      drain();
      check("clamp_no_early_window", WW'(seen_q.size() - base), WW'(0));
      applyStimulus(1'b0, PW'($urandom), w);
      drain();
      check("clamp_first_window", WW'(seen_q.size() - base), WW'(1));

      // Reset mid-frame, then stray non-SOF pixels must be ignored.
      cfg_width = 10'd4;
      for (int i = 1; i <= 10; i++) applyStimulus(i == 1, PW'(i), w);
      do_reset();
      base = seen_q.size();
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, PW'($urandom), w);
      drain();
      check("idle_drop_no_window", WW'(seen_q.size() - base), WW'(0));
      frame16(1'b0);
`ifdef CONV_LB_FRAME_CNT_EN
      check("frame_cnt_1", WW'(frame_cnt), WW'(1));
      check("win_cnt_1",   WW'(win_cnt),   WW'(4));
`endif
      frame16(1'b0);
`ifdef CONV_LB_FRAME_CNT_EN
      check("frame_cnt_2", WW'(frame_cnt), WW'(2));
      check("win_cnt_2",   WW'(win_cnt),   WW'(4));
`endif

      // Random frames with random backpressure, some cut short by a new SOF.
      rand_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         cfg_width = 10'($urandom_range(3, 12));
         rows      = $urandom_range(3, 5);
         npix      = int'(cfg_width) * rows;
         if (f % 3 == 2) npix = npix - $urandom_range(1, int'(cfg_width));
         for (int i = 0; i < npix; i++) applyStimulus(i == 0, PW'($urandom), w);
      end
      drain();
      rand_ready = 1'b0;
      check("scoreboard_empty", WW'(exp_q.size()), WW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_line_buffer.md
CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 64, meaning the maximum image line length in pixels.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the pixel width in bits.
REQ-003 SHALL have HCLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cfg_width  input  10  active line length; sampled only on an accepted SOF pixel.
REQ-006 SHALL have pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have pix_sof  input  1  marks the first pixel of a frame; qualified by pix_valid.
REQ-008 SHALL have pix_data  input  PIX_W  pixel value.
REQ-009 SHALL have pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-010 SHALL have win_valid  output  1  3x3 window valid.
REQ-011 SHALL have win_ready  input  1  downstream convolver accepts the window.
REQ-012 SHALL have win_data  output  9*PIX_W  window; [71:64]=top-left ... [7:0]=bottom-right, row-major, matching convolver weights wa..wi.

Function
REQ-013 SHALL keep two row stores of MAX_WIDTH entries (row1 = previous line, row2 = the line before that) plus a 3x3 window shift register.
REQ-014 On each accepted pixel at column col, SHALL shift the window left and insert the new right column {row2[col], row1[col], pix_data}, then write row2[col]<=row1[col] and row1[col]<=pix_data.
REQ-015 SHALL run a three-state FSM:
- IDLE: non-SOF pixels accepted and dropped.
- FILL: row<2 or col<2.
- RUN: row>=2 and col>=2.
REQ-016 FSM transitions SHALL be:
- Accepted SOF in any state: col=0, row=0, latch eff_width, go to FILL; the SOF pixel is processed as pixel (0,0).
- FILL->RUN when the accepted pixel has row>=2 and col>=2.
- RUN->FILL when col wraps.
REQ-017 col SHALL wrap from eff_width-1 to 0 and increment row; row SHALL saturate at 1023.
REQ-018 eff_width SHALL equal min(cfg_width, MAX_WIDTH).
REQ-019 If eff_width<3, SHALL accept pixels but never assert win_valid.
REQ-020 An accepted pixel in RUN SHALL produce win_valid on the next cycle (latency 1).
REQ-021 win_valid/win_data SHALL hold stable until win_ready.
REQ-022 pix_ready SHALL equal !win_valid || win_ready (single-entry skid, no bubble at full rate).
REQ-023 SOF arriving while win_valid is pending SHALL wait for pix_ready; the pending window SHALL still be delivered.

Reset
REQ-024 Asynchronous assertion SHALL set: FSM=IDLE, col=0, row=0, eff_width=MAX_WIDTH, win_valid=0, win_data=0; pix_ready=1 in the first cycle after release.
REQ-025 Row stores SHALL NOT be reset; FILL guarantees stale contents never reach a valid window.
REQ-026 Reset mid-frame SHALL discard the partial window; the first window after reset requires a new SOF.

Configuration
REQ-027 With CONV_LB_FRAME_CNT_EN defined, SHALL add outputs frame_cnt[15:0] (wrapping count of accepted SOFs, reset 0) and win_cnt[15:0] (windows handed off in the current frame, cleared on SOF, reset 0).
REQ-028 Without CONV_LB_FRAME_CNT_EN, those ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-029 Package conv_pkg SHALL hold PIX_W default, the lb_state_e enum (IDLE/FILL/RUN) and the window-index constants for win_data slicing.
REQ-030 SHALL instantiate sub-module conv_row_ram (1 read + 1 write per cycle, same address, read-before-write) twice, once per row store.

Verification
REQ-031 Width 4, pixels 1..16 with SOF on pixel 1, win_ready=1 -> 4 windows; first = {1,2,3,5,6,7,9,10,11}, last = {6,7,8,10,11,12,14,15,16}.
REQ-032 Same stimulus, win_ready low 3 cycles on the first window -> win_data held, pix_ready=0 for those cycles, no window lost or duplicated.
REQ-033 cfg_width=2, 10 pixels -> win_valid never asserted, all pixels accepted.
REQ-034 cfg_width=200 with MAX_WIDTH=64 -> col wraps at 63; first window appears after pixel 2*64+3.
REQ-035 HRESETn pulsed after pixel 10 of REQ-031, then a new SOF frame -> no window before (row 2, col 2) of the new frame.
REQ-036 CONV_LB_FRAME_CNT_EN defined, two REQ-031 frames -> frame_cnt=2, win_cnt=4 at the end of each frame.
